// File: rtl/ifetch_buffer_pkg.sv
// ifetch_buffer_pkg
// Shared definitions for the instruction-fetch buffer:
//   - fetch FSM state encoding
//   - AdEL exception code and the legal instruction-memory window
//   - queue entry layout {pc, instr, exc, exccode} and its width
//   - addr_fault(): misalignment / out-of-window test, used only when the
//     IFETCH_BUFFER_ADDR_CHECK_EN build option is enabled
package ifetch_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DROP  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [4:0]  EXC_ADEL   = 5'd4;
    localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IMEM_LIMIT = 32'h0000_6FFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
        logic [4:0]  exccode;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Word-misaligned or outside the instruction-memory window.
    function automatic logic addr_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < IMEM_BASE) || (addr > IMEM_LIMIT);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo
// DEPTH-entry queue of fetched instructions with wrap-around pointers and an
// occupancy count of 0..DEPTH. The head entry is presented combinationally.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push, push_entry  write an entry at the tail (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   clear             empty the queue at the next edge; overrides push/pop
//   head              current head entry
//   count, full       occupancy and full flag
module ifetch_fifo
    import ifetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_entry,
    input  logic                     pop,
    input  logic                     clear,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1'b1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    entry_t          mem_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW:0]     count_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && (count_r != '0);
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; clear wins over push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_buffer.sv
// ifetch_buffer
// Instruction-fetch front end: issues one instruction-memory read at a time
// from the current PC, queues the returned words for decode, and steps the
// PC register (pc_we) once per accepted word. A flush empties the queue and
// lets the PC load its redirect target; a read still in flight at that
// moment is dropped when it returns.
// Build option IFETCH_BUFFER_ADDR_CHECK_EN: a misaligned or out-of-window PC
// queues an AdEL fault entry instead of fetching, and fetch halts until a
// flush. Without it no check is made and dec_exc/dec_exccode are 0.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   pc, pc_we                     PC value in, PC load enable out
//   flush                         redirect taken this cycle
//   imem_req/addr/ack/rdata       instruction-memory read handshake
//   dec_valid/ready               head entry handshake towards decode
//   dec_instr/pc/exc/exccode      head entry contents
// DEPTH must be a power of two, at least 2.
module ifetch_buffer
    import ifetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_we,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        dec_exc,
    output logic [4:0]  dec_exccode
);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   req_s;
    logic                   we_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   clear_s;
    logic                   full_s;
    logic                   valid_s;
    entry_t                 push_entry_s;
    entry_t                 head_s;
    logic [$clog2(DEPTH):0] count_s;

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .clear      (clear_s),
        .head       (head_s),
        .count      (count_s),
        .full       (full_s)
    );

    assign valid_s = (count_s != '0);

    // Fetch FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, memory request, PC step and queue control.
    always_comb begin
        state_nxt_s  = state_r;
        req_s        = 1'b0;
        we_s         = 1'b0;
        push_s       = 1'b0;
        clear_s      = 1'b0;
        pop_s        = valid_s && dec_ready;
        push_entry_s = '{pc, imem_rdata, 1'b0, 5'd0};
        if (flush) begin
            // Redirect: queue emptied, PC loads the target. A read still in
            // flight must be absorbed in DROP unless it returns right now.
            clear_s = 1'b1;
            we_s    = 1'b1;
            req_s   = (state_r == REQ);
            case (state_r)
                REQ:     state_nxt_s = imem_ack ? IDLE : DROP;
                DROP:    state_nxt_s = imem_ack ? IDLE : DROP;
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    if (!full_s) begin
`ifdef IFETCH_BUFFER_ADDR_CHECK_EN
                        if (addr_fault(pc)) begin
                            push_s       = 1'b1;
                            push_entry_s = '{pc, 32'd0, 1'b1, EXC_ADEL};
                            state_nxt_s  = FAULT;
                        end else begin
                            req_s       = 1'b1;
                            state_nxt_s = REQ;
                        end
`else
                        req_s       = 1'b1;
                        state_nxt_s = REQ;
`endif
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                REQ: begin
                    req_s = 1'b1;
                    if (imem_ack) begin
                        push_s      = 1'b1;
                        we_s        = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = REQ;
                    end
                end
                DROP: begin
                    state_nxt_s = imem_ack ? IDLE : DROP;
                end
                FAULT: begin
                    state_nxt_s = FAULT;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // IDLE requests combinationally, so reset must mask the strobes directly.
    assign imem_req  = req_s & ~reset;
    assign pc_we     = we_s & ~reset;
    assign imem_addr = pc;
    assign dec_valid = valid_s;
    assign dec_instr = head_s.instr;
    assign dec_pc    = head_s.pc;

`ifdef IFETCH_BUFFER_ADDR_CHECK_EN
    assign dec_exc     = head_s.exc;
    assign dec_exccode = head_s.exccode;
`else
    logic unused_exc_s;
    assign unused_exc_s = ^{head_s.exc, head_s.exccode};
    assign dec_exc      = 1'b0;
    assign dec_exccode  = 5'd0;
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer (DEPTH=4). Inputs change 1 time unit
// after the rising edge, outputs are checked on the falling edge. The bench
// plays the PC register: when pc_we is seen high it loads pc+4, or the
// redirect target if flush was high in the same cycle.
module tb_ifetch_buffer;
    import ifetch_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_we;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_exc;
    logic [4:0]  dec_exccode;
    logic [31:0] tgt;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    ifetch_buffer #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_we       (pc_we),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_exc     (dec_exc),
        .dec_exccode (dec_exccode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called after the falling edge: advance one rising edge and model the PC.
    task automatic nxt();
        logic we;
        logic fl;
        we = pc_we;
        fl = flush;
        @(posedge clk);
        #1;
        if (we) pc = fl ? tgt : pc + 32'd4;
    endtask

    task automatic do_reset(input logic [31:0] new_pc);
        reset    = 1'b1;
        flush    = 1'b0;
        imem_ack = 1'b0;
        pc       = new_pc;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pc = 32'h0000_3000; flush = 1'b0; imem_ack = 1'b0;
        imem_rdata = 32'd0; dec_ready = 1'b0; tgt = 32'd0;

        // ---- reset state
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_we", {31'd0, pc_we}, 32'd0);
        chk("rst_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_instr", dec_instr, 32'd0);
        chk("rst_pc", dec_pc, 32'd0);
        chk("rst_exc", {26'd0, dec_exc, dec_exccode}, 32'd0);
        chk("rst_state", 32'(dut.state_r), 32'(IDLE));
        @(posedge clk); #1;
        reset = 1'b0;

        // ---- 1: streaming, ack latency 1, decode always ready
        dec_ready = 1'b1;
        @(negedge clk);
        chk("s1_req_first", {31'd0, imem_req}, 32'd1);
        chk("s1_addr", imem_addr, 32'h0000_3000);
        nxt();
        imem_ack = 1'b1; imem_rdata = 32'hA000_0000;
        @(negedge clk);
        chk("s1_we_ack0", {31'd0, pc_we}, 32'd1);
        chk("s1_empty", {31'd0, dec_valid}, 32'd0);
        nxt();
        imem_ack = 1'b0;
        @(negedge clk);
        chk("s1_valid", {31'd0, dec_valid}, 32'd1);
        chk("s1_instr0", dec_instr, 32'hA000_0000);
        chk("s1_pc0", dec_pc, 32'h0000_3000);
        chk("s1_we_idle", {31'd0, pc_we}, 32'd0);
        chk("s1_addr1", imem_addr, 32'h0000_3004);
        nxt();
        imem_ack = 1'b1; imem_rdata = 32'hA000_0001;
        @(negedge clk);
        chk("s1_we_ack1", {31'd0, pc_we}, 32'd1);
        nxt();
        imem_ack = 1'b0;
        @(negedge clk);
        chk("s1_instr1", dec_instr, 32'hA000_0001);
        chk("s1_pc1", dec_pc, 32'h0000_3004);
        nxt();

        // ---- 2: decode stalled, queue fills to DEPTH then drains in order
        do_reset(32'h0000_3000);
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            chk("s2_req", {31'd0, imem_req}, 32'd1);
            nxt();
            imem_ack = 1'b1; imem_rdata = 32'hB000_0000 + 32'(i);
            @(negedge clk);
            chk("s2_we", {31'd0, pc_we}, 32'd1);
            nxt();
        end
        imem_ack = 1'b0;
        @(negedge clk);
        chk("s2_full_req", {31'd0, imem_req}, 32'd0);
        chk("s2_full_we", {31'd0, pc_we}, 32'd0);
        chk("s2_full_cnt", 32'(dut.u_fifo.count_r), 32'd4);
        nxt();
        imem_ack = 1'b1;
        @(negedge clk);
        chk("s2_stray_ack_we", {31'd0, pc_we}, 32'd0);
        nxt();
        imem_ack = 1'b0; dec_ready = 1'b1;
        @(negedge clk);
        chk("s2_stray_ack_cnt", 32'(dut.u_fifo.count_r), 32'd4);
        chk("s2_pc0", dec_pc, 32'h0000_3000);
        chk("s2_instr0", dec_instr, 32'hB000_0000);
        nxt();
        @(negedge clk);
        chk("s2_pc1", dec_pc, 32'h0000_3004);
        chk("s2_instr1", dec_instr, 32'hB000_0001);
        chk("s2_req_after_pop", {31'd0, imem_req}, 32'd1);
        nxt();
        imem_ack = 1'b1; imem_rdata = 32'hC000_0000;
        @(negedge clk);
        chk("s2_pc2", dec_pc, 32'h0000_3008);
        chk("s2_instr2", dec_instr, 32'hB000_0002);
        nxt();
        imem_ack = 1'b0;
        @(negedge clk);
        chk("s2_pushpop_cnt", 32'(dut.u_fifo.count_r), 32'd2);
        chk("s2_pc3", dec_pc, 32'h0000_300C);
        chk("s2_instr3", dec_instr, 32'hB000_0003);
        nxt();
        @(negedge clk);
        chk("s2_pc4", dec_pc, 32'h0000_3010);
        chk("s2_instr4", dec_instr, 32'hC000_0000);
        nxt();
        @(negedge clk);
        chk("s2_drained", {31'd0, dec_valid}, 32'd0);
        nxt();

        // ---- 3: flush during REQ, late ack dropped
        do_reset(32'h0000_3000);
        dec_ready = 1'b0;
        @(negedge clk); nxt();
        imem_ack = 1'b1; imem_rdata = 32'hD000_0000;
        @(negedge clk); nxt();
        imem_ack = 1'b0;
        @(negedge clk);
        chk("s3_one_entry", {31'd0, dec_valid}, 32'd1);
        nxt();
        flush = 1'b1; tgt = 32'h0000_4180;
        @(negedge clk);
        chk("s3_flush_we", {31'd0, pc_we}, 32'd1);
        nxt();
        flush = 1'b0;
        @(negedge clk);
        chk("s3_state_drop", 32'(dut.state_r), 32'(DROP));
        chk("s3_emptied", {31'd0, dec_valid}, 32'd0);
        chk("s3_drop_req", {31'd0, imem_req}, 32'd0);
        chk("s3_drop_we", {31'd0, pc_we}, 32'd0);
        nxt();
        @(negedge clk); nxt();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_0000;
        @(negedge clk);
        chk("s3_late_ack_we", {31'd0, pc_we}, 32'd0);
        chk("s3_late_ack_req", {31'd0, imem_req}, 32'd0);
        nxt();
        imem_ack = 1'b0;
        @(negedge clk);
        chk("s3_no_push", 32'(dut.u_fifo.count_r), 32'd0);
        chk("s3_refetch_req", {31'd0, imem_req}, 32'd1);
        chk("s3_refetch_addr", imem_addr, 32'h0000_4180);
        chk("s3_refetch_we", {31'd0, pc_we}, 32'd0);
        nxt();

        // ---- 4: flush and ack in the same cycle
        imem_ack = 1'b1; imem_rdata = 32'hEEEE_0000; flush = 1'b1; tgt = 32'h0000_5000;
        @(negedge clk);
        chk("s4_we", {31'd0, pc_we}, 32'd1);
        nxt();
        imem_ack = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("s4_state_idle", 32'(dut.state_r), 32'(IDLE));
        chk("s4_no_push", {31'd0, dec_valid}, 32'd0);
        chk("s4_addr", imem_addr, 32'h0000_5000);
        nxt();

        // ---- 5: misaligned PC
        do_reset(32'h0000_3002);
        dec_ready = 1'b0;
`ifdef IFETCH_BUFFER_ADDR_CHECK_EN
        @(negedge clk);
        chk("s5_no_req", {31'd0, imem_req}, 32'd0);
        chk("s5_no_we", {31'd0, pc_we}, 32'd0);
        nxt();
        @(negedge clk);
        chk("s5_valid", {31'd0, dec_valid}, 32'd1);
        chk("s5_exc", {31'd0, dec_exc}, 32'd1);
        chk("s5_code", {27'd0, dec_exccode}, 32'd4);
        chk("s5_pc", dec_pc, 32'h0000_3002);
        chk("s5_state", 32'(dut.state_r), 32'(FAULT));
        nxt();
        @(negedge clk);
        chk("s5_halted", {31'd0, imem_req}, 32'd0);
        nxt();
        flush = 1'b1; tgt = 32'h0000_3000;
        @(negedge clk);
        chk("s5_flush_we", {31'd0, pc_we}, 32'd1);
        nxt();
        flush = 1'b0;
        @(negedge clk);
        chk("s5_resume", {31'd0, imem_req}, 32'd1);
        chk("s5_cleared", {31'd0, dec_valid}, 32'd0);
        nxt();
`else
        @(negedge clk);
        chk("s5_nochk_req", {31'd0, imem_req}, 32'd1);
        nxt();
        imem_ack = 1'b1; imem_rdata = 32'hABCD_0000;
        @(negedge clk); nxt();
        imem_ack = 1'b0;
        @(negedge clk);
        chk("s5_nochk_valid", {31'd0, dec_valid}, 32'd1);
        chk("s5_nochk_exc", {26'd0, dec_exc, dec_exccode}, 32'd0);
        chk("s5_nochk_pc", dec_pc, 32'h0000_3002);
        nxt();
`endif

        // ---- 6: reset mid-REQ, ack after release
        do_reset(32'h0000_3000);
        dec_ready = 1'b0;
        @(negedge clk); nxt();
        @(negedge clk);
        chk("s6_in_req", 32'(dut.state_r), 32'(REQ));
        reset = 1'b1;
        #1;
        chk("s6_rst_req", {31'd0, imem_req}, 32'd0);
        chk("s6_rst_state", 32'(dut.state_r), 32'(IDLE));
        @(posedge clk); #1;
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("s6_late_we", {31'd0, pc_we}, 32'd0);
        nxt();
        imem_ack = 1'b0;
        @(negedge clk);
        chk("s6_cnt", 32'(dut.u_fifo.count_r), 32'd0);
        chk("s6_valid", {31'd0, dec_valid}, 32'd0);
        chk("s6_we", {31'd0, pc_we}, 32'd0);
        nxt();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
